// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state, parity type and data-width bounds for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2, DONE} state_t;
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} par_type_t;
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int BIT_CNT_W = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter whose synchronous clear beats increment
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: frames oversampled UART bits, checks parity/stop and counts errors
module uart_rx_frame_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sampled_bit_in,
    input  logic                     sample_valid_in,
    input  logic                     par_en_in,
    input  logic                     par_type_in,
    input  logic                     stop2_in,
    input  logic                     cnt_clr_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid_out,
    output logic                     par_err_out,
    output logic                     stp_err_out,
    output logic [ERR_CNT_WIDTH-1:0] par_err_cnt_out,
    output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt_out,
    output logic                     busy_out
);
    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX)
        $error("DATA_WIDTH out of range");

    localparam logic [BIT_CNT_W-1:0] LAST = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                  state, next_state;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    perr, serr, par_en_q, stop2_q, pend_v, pend_b;
    par_type_t               par_type_q;
    logic                    stb, bit_v, start;

    // a strobe landing in DONE is replayed into IDLE on the following cycle
    assign stb   = sample_valid_in | pend_v;
    assign bit_v = pend_v ? pend_b : sampled_bit_in;
    assign start = state == IDLE && stb && !bit_v;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? DATA : IDLE;
            DATA:    if (stb && bit_cnt == LAST) next_state = par_en_q ? PARITY : STOP1;
            PARITY:  next_state = stb ? STOP1 : PARITY;
            STOP1:   if (stb) next_state = stop2_q ? STOP2 : DONE;
            STOP2:   next_state = stb ? DONE : STOP2;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_out       = state != IDLE;
        data_valid_out = state == DONE && !perr && !serr;
        par_err_out    = state == DONE && perr;
        stp_err_out    = state == DONE && serr;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            serr       <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= EVEN;
            stop2_q    <= 1'b0;
            pend_v     <= 1'b0;
            pend_b     <= 1'b0;
            data_out   <= '0;
        end else begin
            pend_v <= state == DONE && sample_valid_in;
            pend_b <= sampled_bit_in;
            if (start) begin
                bit_cnt    <= '0;
                perr       <= 1'b0;
                serr       <= 1'b0;
                par_en_q   <= par_en_in;
                par_type_q <= par_type_t'(par_type_in);
                stop2_q    <= stop2_in;
            end
            if (state == DATA && stb) begin
                shreg   <= {bit_v, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == PARITY && stb) perr <= (^shreg ^ bit_v) != (par_type_q == ODD);
            if ((state == STOP1 || state == STOP2) && stb && !bit_v) serr <= 1'b1;
            if (next_state == DONE) data_out <= shreg;
        end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr_in), .inc(par_err_out), .count(par_err_cnt_out)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr_in), .inc(stp_err_out), .count(stp_err_cnt_out)
    );
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: scoreboard bench driving an 8-bit and a 7-bit receiver
module tb_uart_rx_frame_check;
    typedef struct {
        logic [8:0] data;
        logic       v, pe, se;
        int         due;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, line = 1'b1, sv8 = 1'b0, sv7 = 1'b0;
    logic par_en = 1'b0, par_type = 1'b0, stop2 = 1'b0, cnt_clr = 1'b0;
    logic [7:0] d8;
    logic [6:0] d7;
    logic       v8, pe8, se8, b8, v7, pe7, se7, b7;
    logic [1:0] pc8, sc8;
    logic [7:0] pc7, sc7;
    int   cyc = 0, checks = 0, errors = 0;
    exp_t q8[$], q7[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_check #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u8 (
        .clk(clk), .reset(reset), .sampled_bit_in(line), .sample_valid_in(sv8),
        .par_en_in(par_en), .par_type_in(par_type), .stop2_in(stop2), .cnt_clr_in(cnt_clr),
        .data_out(d8), .data_valid_out(v8), .par_err_out(pe8), .stp_err_out(se8),
        .par_err_cnt_out(pc8), .stp_err_cnt_out(sc8), .busy_out(b8)
    );

    uart_rx_frame_check #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(8)) u7 (
        .clk(clk), .reset(reset), .sampled_bit_in(line), .sample_valid_in(sv7),
        .par_en_in(par_en), .par_type_in(par_type), .stop2_in(stop2), .cnt_clr_in(cnt_clr),
        .data_out(d7), .data_valid_out(v7), .par_err_out(pe7), .stp_err_out(se7),
        .par_err_cnt_out(pc7), .stp_err_cnt_out(sc7), .busy_out(b7)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input string name, input logic [8:0] d, input logic v, input logic pe,
                       input logic se, input bit empty, input exp_t e);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL %s: unexpected pulse v=%b pe=%b se=%b data=%0h", name, v, pe, se, d);
        end else if (d !== e.data || v !== e.v || pe !== e.pe || se !== e.se || cyc != e.due) begin
            errors++;
            $display("FAIL %s: got data=%0h v=%b pe=%b se=%b cyc=%0d expected data=%0h v=%b pe=%b se=%b cyc=%0d",
                     name, d, v, pe, se, cyc, e.data, e.v, e.pe, e.se, e.due);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v8 | pe8 | se8) begin
            e = '{data: '0, v: 0, pe: 0, se: 0, due: 0};
            if (q8.size() != 0) e = q8.pop_front();
            mon("frame8", {1'b0, d8}, v8, pe8, se8, q8.size() == 0 && e.due == 0, e);
        end
        if (v7 | pe7 | se7) begin
            e = '{data: '0, v: 0, pe: 0, se: 0, due: 0};
            if (q7.size() != 0) e = q7.pop_front();
            mon("frame7", {2'b0, d7}, v7, pe7, se7, q7.size() == 0 && e.due == 0, e);
        end
    end

    task automatic strobe(input logic b, input bit s7);
        @(negedge clk);
        line = b;
        if (s7) sv7 = 1'b1; else sv8 = 1'b1;
        @(negedge clk);
        sv7 = 1'b0;
        sv8 = 1'b0;
        line = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cfg(input logic pen, input logic pt, input logic s2);
        par_en = pen;
        par_type = pt;
        stop2 = s2;
    endtask

    task automatic send_frame(input bit s7, input logic [8:0] d, input int nb, input logic pb,
                              input logic sa, input logic sb, input bit flip, input bit clr,
                              input logic [8:0] ed, input logic ev, input logic epe, input logic ese);
        exp_t e;
        logic pen, two, last;
        pen = par_en;
        two = stop2;
        strobe(1'b0, s7);
        for (int i = 0; i < nb; i++) begin
            strobe(d[i], s7);
            if (flip && i == 3) begin
                par_type = ~par_type;
                par_en = ~par_en;
                stop2 = ~stop2;
            end
        end
        if (pen) strobe(pb, s7);
        last = sa;
        if (two) begin
            strobe(sa, s7);
            last = sb;
        end
        @(negedge clk);
        line = last;
        if (s7) sv7 = 1'b1; else sv8 = 1'b1;
        e = '{data: ed, v: ev, pe: epe, se: ese, due: cyc + 1};
        if (s7) q7.push_back(e); else q8.push_back(e);
        @(negedge clk);
        sv7 = 1'b0;
        sv8 = 1'b0;
        line = 1'b1;
        cnt_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        repeat (2) @(negedge clk);
        chk("rst_busy", b8, 0);
        chk("rst_data", d8, 0);
        chk("rst_pulses", {v8, pe8, se8}, 0);
        chk("rst_cnt", {pc8, sc8}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", b8, 0);

        cfg(0, 0, 0);
        send_frame(0, 9'h0A5, 8, 0, 1, 1, 0, 0, 9'h0A5, 1, 0, 0);
        chk("8n1_data_hold", d8, 8'hA5);
        chk("8n1_cnt", {pc8, sc8}, 0);

        cfg(1, 0, 0);
        send_frame(0, 9'h007, 8, 0, 1, 1, 0, 0, 9'h007, 0, 1, 0);
        chk("8e1_par_cnt", pc8, 1);

        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        chk("clr_par_cnt", pc8, 0);

        for (int i = 0; i < 5; i++) begin
            send_frame(0, 9'h007, 8, 0, 1, 1, 0, 0, 9'h007, 0, 1, 0);
            chk($sformatf("sat_cnt_%0d", i), pc8, exp_cnt[i]);
        end
        send_frame(0, 9'h007, 8, 0, 1, 1, 0, 1, 9'h007, 0, 1, 0);
        chk("clr_wins", pc8, 0);

        cfg(1, 1, 1);
        send_frame(1, 9'h055, 7, 1, 1, 0, 0, 0, 9'h055, 0, 0, 1);
        chk("7o2_stp_cnt", sc7, 1);
        chk("7o2_par_cnt", pc7, 0);

        cfg(1, 1, 0);
        send_frame(0, 9'h0A5, 8, 1, 1, 1, 1, 0, 9'h0A5, 1, 0, 0);
        chk("8o1_flip_par_cnt", pc8, 0);

        cfg(0, 0, 0);
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(i[0], 0);
        chk("midframe_busy", b8, 1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", b8, 0);
        chk("midrst_data", d8, 0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(0, 9'h03C, 8, 0, 1, 1, 0, 0, 9'h03C, 1, 0, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_hold", d8, 8'h3C);
        chk("q8_drained", q8.size(), 0);
        chk("q7_drained", q7.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
